// File: rtl/branch_resolve_if.sv
// Resolve-stage bus for branch_resolve: request/comparator inputs, fetch redirect
// handshake, link write-back and exception outputs. BRANCH_STATS_EN adds br_count/taken_count.
interface branch_resolve_if #(
   parameter int n = 32
);
   logic         in_valid;
   logic         in_ready;
   logic         is_branch;
   logic         is_jal;
   logic         is_jalr;
   logic [2:0]   funct3;
   logic         BrEq;
   logic         BrLT;
   logic         BrUn;
   logic [n-1:0] pc;
   logic [n-1:0] imm;
   logic [n-1:0] rs1;
   logic         redirect_valid;
   logic [n-1:0] redirect_pc;
   logic         redirect_ready;
   logic         flush;
   logic         link_valid;
   logic [n-1:0] link_data;
   logic         misalign_exc;
`ifdef BRANCH_STATS_EN
   logic [n-1:0] br_count;
   logic [n-1:0] taken_count;
`endif

   // Pipeline/fetch side: issues requests, consumes redirects.
   modport master (
      output in_valid, is_branch, is_jal, is_jalr, funct3, BrEq, BrLT,
             pc, imm, rs1, redirect_ready,
      input  in_ready, BrUn, redirect_valid, redirect_pc, flush,
             link_valid, link_data, misalign_exc
`ifdef BRANCH_STATS_EN
      , input br_count, taken_count
`endif
   );

   // Resolver side.
   modport slave (
      input  in_valid, is_branch, is_jal, is_jalr, funct3, BrEq, BrLT,
             pc, imm, rs1, redirect_ready,
      output in_ready, BrUn, redirect_valid, redirect_pc, flush,
             link_valid, link_data, misalign_exc
`ifdef BRANCH_STATS_EN
      , output br_count, taken_count
`endif
   );
endinterface

// File: rtl/branch_resolve.sv
// Branch/jump resolver: evaluates conditions, computes targets, drives a held fetch redirect,
// a flush window of FLUSH_CYCLES (1..7) and jal/jalr link write-back. Optional: BRANCH_STATS_EN.
module branch_resolve #(
   parameter int n            = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input logic         clk,
   input logic         rst_n,
   branch_resolve_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_e;

   state_e       state;
   logic [2:0]   flushCounter;
   logic         redirectValid;
   logic [n-1:0] redirectPc;
   logic         flushReg;
   logic         linkValid;
   logic [n-1:0] linkData;
   logic         misalignExc;

   logic         condMet;
   logic         takenNow;
   logic         isJump;
   logic         accept;
   logic [n-1:0] pcTarget;
   logic [n-1:0] jalrSum;
   logic [n-1:0] target;
   logic [n-1:0] linkNext;

   function automatic logic branchCond(input logic [2:0] f3, input logic eq, input logic lt);
      logic r;
      r = 1'b0;
      case (f3)
         3'b000:         r = eq;
         3'b001:         r = !eq;
         3'b100, 3'b110: r = lt;
         3'b101, 3'b111: r = !lt;
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

   // The comparator needs the signedness select in the same cycle it evaluates.
   assign bus.BrUn = bus.funct3[1];

   assign condMet  = branchCond(bus.funct3, bus.BrEq, bus.BrLT);
   assign isJump   = bus.is_jal | bus.is_jalr;
   assign takenNow = isJump | (bus.is_branch & condMet);
   assign accept   = bus.in_valid && (state == IDLE);

   assign pcTarget = bus.pc + bus.imm;
   assign jalrSum  = bus.rs1 + bus.imm;
   assign target   = bus.is_jalr ? (jalrSum & ~n'(1)) : pcTarget;
   assign linkNext = bus.pc + n'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         flushCounter  <= 3'd0;
         redirectValid <= 1'b0;
         redirectPc    <= '0;
         flushReg      <= 1'b0;
         linkValid     <= 1'b0;
         linkData      <= '0;
         misalignExc   <= 1'b0;
      end else begin
         linkValid   <= 1'b0;
         misalignExc <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && takenNow) begin
                  if (target[1]) begin
                     misalignExc <= 1'b1;
                  end else begin
                     redirectPc    <= target;
                     redirectValid <= 1'b1;
                     flushReg      <= 1'b1;
                     state         <= REDIRECT;
                     if (isJump) begin
                        linkValid <= 1'b1;
                        linkData  <= linkNext;
                     end
                  end
               end
            end
            REDIRECT: begin
               // Redirect is held until fetch takes it; flush stays up meanwhile.
               if (bus.redirect_ready) begin
                  redirectValid <= 1'b0;
                  flushCounter  <= 3'(FLUSH_CYCLES - 1);
                  state         <= FLUSH;
               end
            end
            FLUSH: begin
               if (flushCounter == 3'd0) begin
                  flushReg <= 1'b0;
                  state    <= IDLE;
               end else begin
                  flushCounter <= flushCounter - 3'd1;
               end
            end
            default: begin
               state         <= IDLE;
               redirectValid <= 1'b0;
               flushReg      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready       = (state == IDLE);
   assign bus.redirect_valid = redirectValid;
   assign bus.redirect_pc    = redirectPc;
   assign bus.flush          = flushReg;
   assign bus.link_valid     = linkValid;
   assign bus.link_data      = linkData;
   assign bus.misalign_exc   = misalignExc;

`ifdef BRANCH_STATS_EN
   logic [n-1:0] brCount;
   logic [n-1:0] takenCount;

   // Saturating event counters; misaligned taken jumps still count as taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brCount    <= '0;
         takenCount <= '0;
      end else if (accept) begin
         if (bus.is_branch && (brCount != '1)) begin
            brCount <= brCount + n'(1);
         end
         if (takenNow && (takenCount != '1)) begin
            takenCount <= takenCount + n'(1);
         end
      end
   end

   assign bus.br_count    = brCount;
   assign bus.taken_count = takenCount;
`endif

   property pRedirectHeld;
      @(posedge clk) disable iff (!rst_n)
         (redirectValid && !bus.redirect_ready) |=> (redirectValid && $stable(redirectPc));
   endproperty
   aRedirectHeld: assert property (pRedirectHeld);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed table-driven bench for branch_resolve plus hand sequences for the held
// redirect / flush length and reset during flush.
module tb_branch_resolve;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   branch_resolve_if #(.n(32)) bus ();

   branch_resolve #(.n(32), .FLUSH_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        isBranch;
      logic        isJal;
      logic        isJalr;
      logic [2:0]  f3;
      logic        eq;
      logic        lt;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        expBrUn;
      logic        expRedir;
      logic [31:0] expPc;
      logic        expLink;
      logic [31:0] expLinkData;
      logic        expMis;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1);
      bus.is_branch = br;
      bus.is_jal    = jal;
      bus.is_jalr   = jalr;
      bus.funct3    = f3;
      bus.BrEq      = eq;
      bus.BrLT      = lt;
      bus.pc        = pc;
      bus.imm       = imm;
      bus.rs1       = rs1;
   endtask

   task automatic waitIdle(input string name);
      for (int c = 0; c < 20 && !bus.in_ready; c++) begin
         @(posedge clk);
         #1;
      end
      check(name, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int expBr;
      int expTaken;
      int flushCnt;
      tests = 0;
      fails = 0;
      expBr = 0;
      expTaken = 0;

      //                 br jal jalr f3   eq lt pc            imm           rs1           un rd expPc        lk linkData     mis
      vecs[0]  = '{1'b1,1'b0,1'b0,3'b100,1'b0,1'b0,32'h100,     32'h20,      32'h0,    1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,3'b110,1'b0,1'b1,32'h100,     32'h20,      32'h0,    1'b1,1'b1,32'h120,  1'b0,32'h0,  1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b0,3'b000,1'b1,1'b0,32'hFFFFFFFC,32'h8,       32'h0,    1'b0,1'b1,32'h4,    1'b0,32'h0,  1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b0,3'b001,1'b1,1'b0,32'h400,     32'h10,      32'h0,    1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,3'b101,1'b0,1'b0,32'h1000,    32'hFFFFFFF0,32'h0,    1'b0,1'b1,32'hFF0,  1'b0,32'h0,  1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b0,3'b010,1'b1,1'b1,32'h100,     32'h20,      32'h0,    1'b1,1'b0,32'h0,    1'b0,32'h0,  1'b0};
      vecs[6]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'h100,     32'h6,       32'h0,    1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b1};
      vecs[7]  = '{1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'h300,     32'h40,      32'h0,    1'b0,1'b1,32'h340,  1'b1,32'h304,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h200,     32'h3,       32'h1001, 1'b0,1'b1,32'h1004, 1'b1,32'h204,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h500,     32'h1,       32'h2000, 1'b0,1'b1,32'h2000, 1'b1,32'h504,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h500,     32'h2,       32'h2000, 1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b1};
      vecs[11] = '{1'b0,1'b0,1'b0,3'b000,1'b1,1'b1,32'h100,     32'h20,      32'h0,    1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,3'b111,1'b0,1'b1,32'h100,     32'h20,      32'h0,    1'b1,1'b0,32'h0,    1'b0,32'h0,  1'b0};
      vecs[13] = '{1'b1,1'b0,1'b0,3'b100,1'b0,1'b1,32'h100,     32'h22,      32'h0,    1'b0,1'b0,32'h0,    1'b0,32'h0,  1'b1};

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.redirect_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #2;
      check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'h0);
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_link_valid", 32'(bus.link_valid), 32'd0);
      check("rst_link_data", bus.link_data, 32'h0);
      check("rst_misalign", 32'(bus.misalign_exc), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].isBranch, vecs[i].isJal, vecs[i].isJalr, vecs[i].f3, vecs[i].eq,
               vecs[i].lt, vecs[i].pc, vecs[i].imm, vecs[i].rs1);
         bus.in_valid = 1'b1;
         #1;
         check($sformatf("v%0d_BrUn", i), 32'(bus.BrUn), 32'(vecs[i].expBrUn));
         check($sformatf("v%0d_in_ready_pre", i), 32'(bus.in_ready), 32'd1);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         expBr    += int'(vecs[i].isBranch);
         expTaken += int'(vecs[i].expRedir | vecs[i].expMis);
         check($sformatf("v%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].expRedir));
         check($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].expRedir));
         check($sformatf("v%0d_link_valid", i), 32'(bus.link_valid), 32'(vecs[i].expLink));
         check($sformatf("v%0d_misalign", i), 32'(bus.misalign_exc), 32'(vecs[i].expMis));
         check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(!vecs[i].expRedir));
         if (vecs[i].expRedir)
            check($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].expPc);
         if (vecs[i].expLink)
            check($sformatf("v%0d_link_data", i), bus.link_data, vecs[i].expLinkData);
         if (vecs[i].expRedir) begin
            bus.redirect_ready = 1'b1;
            waitIdle($sformatf("v%0d_return_idle", i));
            bus.redirect_ready = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            check($sformatf("v%0d_misalign_end", i), 32'(bus.misalign_exc), 32'd0);
            check($sformatf("v%0d_no_redirect", i), 32'(bus.redirect_valid), 32'd0);
         end
         $display("[TB] vector %0d pc=%h applied", i, vecs[i].pc);
      end

`ifdef BRANCH_STATS_EN
      check("stats_br_count", bus.br_count, 32'(expBr));
      check("stats_taken_count", bus.taken_count, 32'(expTaken));
`endif

      // jalr with fetch stalling three cycles; a busy-time request must be ignored.
      drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h200, 32'h3, 32'h1001);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_redirect_pc0", bus.redirect_pc, 32'h1004);
      check("hold_link_valid0", 32'(bus.link_valid), 32'd1);
      check("hold_link_data0", bus.link_data, 32'h204);
      flushCnt = int'(bus.flush);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h4000, 32'h100, 32'h0);
      for (int w = 0; w < 3; w++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold_valid_w%0d", w), 32'(bus.redirect_valid), 32'd1);
         check($sformatf("hold_pc_w%0d", w), bus.redirect_pc, 32'h1004);
         check($sformatf("hold_link_off_w%0d", w), 32'(bus.link_valid), 32'd0);
         flushCnt += int'(bus.flush);
      end
      bus.in_valid = 1'b0;
      bus.redirect_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.redirect_ready = 1'b0;
      check("hold_valid_drop", 32'(bus.redirect_valid), 32'd0);
      flushCnt += int'(bus.flush);
      for (int c = 0; c < 20 && bus.flush; c++) begin
         @(posedge clk);
         #1;
         flushCnt += int'(bus.flush);
      end
      check("hold_flush_cycles", 32'(flushCnt), 32'd6);
      check("hold_in_ready_end", 32'(bus.in_ready), 32'd1);
      check("hold_busy_ignored", 32'(bus.redirect_valid), 32'd0);
      $display("[TB] held jalr redirect, flush cycles %0d", flushCnt);

      // Reset asserted during FLUSH.
      drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h800, 32'h40, 32'h0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.redirect_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.redirect_ready = 1'b0;
      check("rf_in_flush", 32'(bus.flush), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rf_flush_cleared", 32'(bus.flush), 32'd0);
      check("rf_valid_cleared", 32'(bus.redirect_valid), 32'd0);
      check("rf_in_ready", 32'(bus.in_ready), 32'd1);
      check("rf_redirect_pc", bus.redirect_pc, 32'h0);
`ifdef BRANCH_STATS_EN
      check("rf_br_count", bus.br_count, 32'h0);
      check("rf_taken_count", bus.taken_count, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 32'h40, 32'h10, 32'h0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("rf_accept_valid", 32'(bus.redirect_valid), 32'd1);
      check("rf_accept_pc", bus.redirect_pc, 32'h50);
      bus.redirect_ready = 1'b1;
      waitIdle("rf_return_idle");
      bus.redirect_ready = 1'b0;
      $display("[TB] reset during flush sequence done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter: n, 32, datapath/PC width.
REQ-002 Parameter: FLUSH_CYCLES, 2, cycles flush stays high after redirect handshake (legal 1..7).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  resolve request; in_ready  output  1  request accepted when both high.
REQ-006 is_branch, is_jal, is_jalr  input  1 each  instruction class (one-hot or none).
REQ-007 funct3  input  3  branch condition code.
REQ-008 BrEq, BrLT  input  1 each  comparator results for the current request.
REQ-009 BrUn  output  1  unsigned-compare select to comparator, combinational.
REQ-010 pc, imm, rs1  input  n each  instruction PC, sign-extended immediate, rs1 value.
REQ-011 redirect_valid  output  1; redirect_pc  output  n; redirect_ready  input  1  fetch redirect handshake.
REQ-012 flush  output  1  kill younger instructions.
REQ-013 link_valid  output  1; link_data  output  n  rd write-back for jal/jalr.
REQ-014 misalign_exc  output  1  one-cycle pulse, target not 4-byte aligned.

Function
REQ-015 BrUn = funct3[1], valid whenever funct3 driven; no registering.
REQ-016 Condition: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT; 010/011 never taken.
REQ-017 States IDLE, REDIRECT, FLUSH; in_ready = (state == IDLE).
REQ-018 Accept in IDLE: taken = is_jal | is_jalr | (is_branch & condition).
REQ-019 Target: branch/jal pc+imm; jalr (rs1+imm) with bit 0 cleared; sums mod 2^n, wrap-around silent.
REQ-020 Taken with target[1]=1: misalign_exc pulses next cycle, no redirect, no link, stay IDLE.
REQ-021 Taken and aligned: next cycle redirect_pc = target, redirect_valid = 1, flush = 1, state REDIRECT.
REQ-022 Not taken or no class bit: no output activity, stay IDLE, in_ready stays 1.
REQ-023 REDIRECT: redirect_valid and redirect_pc held stable until redirect_ready high at a clock edge.
REQ-024 Handshake in REDIRECT: next cycle redirect_valid = 0, state FLUSH, counter = FLUSH_CYCLES-1.
REQ-025 FLUSH: flush = 1; counter decrements each cycle; at counter 0 return IDLE, flush low next cycle.
REQ-026 flush high in REDIRECT and FLUSH only; total flush cycles = wait cycles + 1 + FLUSH_CYCLES.
REQ-027 jal/jalr accepted (aligned): link_valid pulses 1 cycle, link_data = pc+4, same cycle as redirect_valid rises.
REQ-028 Inputs ignored outside IDLE; in_valid while busy neither accepted nor queued.

Reset
REQ-029 rst_n low asynchronously forces IDLE, counter 0, redirect_valid 0, redirect_pc 0, flush 0, link_valid 0, link_data 0, misalign_exc 0.
REQ-030 Reset mid-REDIRECT/FLUSH aborts pending redirect; first accept possible on first edge after rst_n rises.

Configuration
REQ-031 Macro BRANCH_STATS_EN defined: outputs br_count and taken_count (n bits) added; br_count increments per accepted is_branch, taken_count per taken accept (including jal/jalr); both saturate at all-ones; reset to 0.
REQ-032 BRANCH_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-033 BLT funct3=100, BrUn=0, BrEq=0, BrLT=0 (in0=0x00000001, in1=0x80000001) -> not taken, redirect_valid stays 0, in_ready stays 1.
REQ-034 BLTU funct3=110 -> BrUn=1; BrLT=1, pc=0x100, imm=0x20 -> redirect_pc=0x120, redirect_valid 1 next cycle, flush high.
REQ-035 jalr rs1=0x1001, imm=0x3, pc=0x200 -> redirect_pc=0x1004, link_valid 1, link_data=0x204; redirect_ready held low 3 cycles -> redirect_valid/pc stable, flush high 3+1+2 cycles.
REQ-036 jal pc=0x100, imm=0x6 -> misalign_exc one pulse, no redirect, no link.
REQ-037 pc=0xFFFFFFFC, imm=0x8, BEQ with BrEq=1 -> redirect_pc=0x00000004 (wrap).
REQ-038 rst_n low during FLUSH -> flush and redirect_valid 0 immediately, state IDLE; with BRANCH_STATS_EN counters 0.
